// File: rtl/xadc_pair_sampler_if.sv
// Bundles the XADC DRP bus and the switch/feed pair stream. The sampler uses
// the master modport; the XADC model or consumer side uses the slave modport.
interface xadc_pair_sampler_if;
    logic        eoc_in;
    logic        drdy_in;
    logic [15:0] do_in;
    logic [6:0]  daddr_out;
    logic        den_out;
    logic        dwe_out;
    logic        pair_valid;
    logic        pair_ready;
    logic [11:0] switch_sample;
    logic [11:0] feed_sample;

    modport master (
        input  eoc_in, drdy_in, do_in, pair_ready,
        output daddr_out, den_out, dwe_out, pair_valid, switch_sample, feed_sample
    );

    modport slave (
        output eoc_in, drdy_in, do_in, pair_ready,
        input  daddr_out, den_out, dwe_out, pair_valid, switch_sample, feed_sample
    );
endinterface

// File: rtl/xadc_pair_sampler.sv
// Sequences XADC DRP reads of the switch (VAUX0) then the feed (VAUX1) channel
// and presents each pair on a valid/ready slot. Optional macro DROP_CNT_EN adds drop_count.
module xadc_pair_sampler #(
    parameter logic [6:0] SWITCH_ADDR    = 7'h10,
    parameter logic [6:0] FEED_ADDR      = 7'h11,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  clr,
    xadc_pair_sampler_if.master   bus,
    output logic                  overrun,
    output logic                  timeout_err
`ifdef DROP_CNT_EN
    ,
    output logic [15:0]           drop_count
`endif
);

    localparam logic [1:0] WAIT_SW = 2'd0;
    localparam logic [1:0] RD_SW   = 2'd1;
    localparam logic [1:0] WAIT_FD = 2'd2;
    localparam logic [1:0] RD_FD   = 2'd3;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [6:0]  daddr_q, daddr_d;
    logic        den_q, den_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [11:0] sw_part_q, sw_part_d;
    logic        timeout_q, timeout_d;
    logic        complete;
    logic [7:0]  cnt_inc;

    logic        pv_q, pv_d;
    logic [11:0] sw_q, sw_d;
    logic [11:0] fd_q, fd_d;
    logic        overrun_q, overrun_d;

    assign cnt_inc = cnt_q + 8'd1;

    // Read sequencer; the counter is zeroed when den is issued so it reads 0 in the den cycle.
    always_comb begin
        state_d   = state_q;
        daddr_d   = daddr_q;
        den_d     = 1'b0;
        cnt_d     = cnt_q;
        sw_part_d = sw_part_q;
        timeout_d = 1'b0;
        complete  = 1'b0;
        case (state_q)
            WAIT_SW: if (bus.eoc_in) begin
                den_d   = 1'b1;
                daddr_d = SWITCH_ADDR;
                cnt_d   = 8'd0;
                state_d = RD_SW;
            end
            RD_SW: begin
                cnt_d = cnt_inc;
                if (bus.drdy_in) begin
                    sw_part_d = bus.do_in[15:4];
                    state_d   = WAIT_FD;
                end else if (cnt_inc == TO_LIM) begin
                    timeout_d = 1'b1;
                    sw_part_d = 12'd0;
                    state_d   = WAIT_SW;
                end
            end
            WAIT_FD: if (bus.eoc_in) begin
                den_d   = 1'b1;
                daddr_d = FEED_ADDR;
                cnt_d   = 8'd0;
                state_d = RD_FD;
            end
            RD_FD: begin
                cnt_d = cnt_inc;
                if (bus.drdy_in) begin
                    complete = 1'b1;
                    state_d  = WAIT_SW;
                end else if (cnt_inc == TO_LIM) begin
                    timeout_d = 1'b1;
                    sw_part_d = 12'd0;
                    state_d   = WAIT_SW;
                end
            end
            default: state_d = WAIT_SW;
        endcase
    end

    // Output slot: a completed pair loads when the slot is empty or draining this cycle.
    always_comb begin
        pv_d      = pv_q;
        sw_d      = sw_q;
        fd_d      = fd_q;
        overrun_d = 1'b0;
        if (pv_q && bus.pair_ready) pv_d = 1'b0;
        if (complete) begin
            if (!pv_q || bus.pair_ready) begin
                pv_d = 1'b1;
                sw_d = sw_part_q;
                fd_d = bus.do_in[15:4];
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= WAIT_SW;
            daddr_q   <= SWITCH_ADDR;
            den_q     <= 1'b0;
            cnt_q     <= 8'd0;
            sw_part_q <= 12'd0;
            timeout_q <= 1'b0;
            pv_q      <= 1'b0;
            sw_q      <= 12'd0;
            fd_q      <= 12'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            daddr_q   <= daddr_d;
            den_q     <= den_d;
            cnt_q     <= cnt_d;
            sw_part_q <= sw_part_d;
            timeout_q <= timeout_d;
            pv_q      <= pv_d;
            sw_q      <= sw_d;
            fd_q      <= fd_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef DROP_CNT_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if ((overrun_d || timeout_d) && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) drop_q <= 16'd0;
        else     drop_q <= drop_d;
    end

    assign drop_count = drop_q;
`endif

    assign bus.daddr_out     = daddr_q;
    assign bus.den_out       = den_q;
    assign bus.dwe_out       = 1'b0;
    assign bus.pair_valid    = pv_q;
    assign bus.switch_sample = sw_q;
    assign bus.feed_sample   = fd_q;
    assign overrun           = overrun_q;
    assign timeout_err       = timeout_q;

endmodule

// File: tb/tb_xadc_pair_sampler.sv
// Directed bench for xadc_pair_sampler, built with TIMEOUT_CYCLES=8.
module tb_xadc_pair_sampler;
    logic clk = 1'b0;
    logic clr = 1'b1;
    logic overrun, timeout_err;
`ifdef DROP_CNT_EN
    logic [15:0] drop_count;
`endif
    int total = 0;
    int bad   = 0;
    int den_cnt = 0;
    int ovr_cnt = 0;

    xadc_pair_sampler_if xif ();

    xadc_pair_sampler #(.TIMEOUT_CYCLES(8)) u_dut (
        .clk         (clk),
        .clr         (clr),
        .bus         (xif),
        .overrun     (overrun),
        .timeout_err (timeout_err)
`ifdef DROP_CNT_EN
        ,
        .drop_count  (drop_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (xif.den_out) den_cnt++;
        if (overrun)     ovr_cnt++;
    end

    // Advance one cycle; inputs set now are seen at the next edge, outputs read after it.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic eoc_pulse();
        xif.eoc_in = 1'b1; step(); xif.eoc_in = 1'b0;
    endtask

    task automatic drdy_pulse(input logic [15:0] d);
        xif.do_in = d; xif.drdy_in = 1'b1; step(); xif.drdy_in = 1'b0; xif.do_in = 16'h0;
    endtask

    task automatic do_pair(input logic [15:0] s, input logic [15:0] f);
        eoc_pulse(); step(2); drdy_pulse(s);
        eoc_pulse(); step(2); drdy_pulse(f);
    endtask

    task automatic drain();
        xif.pair_ready = 1'b1; step(); xif.pair_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (xif.daddr_out !== 7'h10) begin bad++; $display("FAIL rst_daddr got=%h exp=10", xif.daddr_out); end
        total++; if (xif.den_out !== 1'b0) begin bad++; $display("FAIL rst_den got=%b exp=0", xif.den_out); end
        total++; if (xif.dwe_out !== 1'b0) begin bad++; $display("FAIL rst_dwe got=%b exp=0", xif.dwe_out); end
        total++; if (xif.pair_valid !== 1'b0) begin bad++; $display("FAIL rst_pv got=%b exp=0", xif.pair_valid); end
        total++; if (xif.switch_sample !== 12'h0 || xif.feed_sample !== 12'h0) begin
            bad++; $display("FAIL rst_samples got=%h/%h exp=0/0", xif.switch_sample, xif.feed_sample); end
        total++; if (overrun !== 1'b0 || timeout_err !== 1'b0) begin
            bad++; $display("FAIL rst_pulses got=%b/%b exp=0/0", overrun, timeout_err); end
`ifdef DROP_CNT_EN
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL rst_drop got=%0d exp=0", drop_count); end
`endif
    endtask

    task automatic test_basic();
        eoc_pulse();
        total++; if (xif.den_out !== 1'b1 || xif.daddr_out !== 7'h10) begin
            bad++; $display("FAIL basic_den_sw got=%b/%h exp=1/10", xif.den_out, xif.daddr_out); end
        step();
        total++; if (xif.den_out !== 1'b0) begin bad++; $display("FAIL basic_den_width got=%b exp=0", xif.den_out); end
        step(); drdy_pulse(16'hABC0);
        eoc_pulse();
        total++; if (xif.den_out !== 1'b1 || xif.daddr_out !== 7'h11) begin
            bad++; $display("FAIL basic_den_fd got=%b/%h exp=1/11", xif.den_out, xif.daddr_out); end
        step(2);
        xif.do_in = 16'h1230; xif.drdy_in = 1'b1;
        #1;
        total++; if (xif.pair_valid !== 1'b0) begin bad++; $display("FAIL basic_pv_early got=%b exp=0", xif.pair_valid); end
        step(); xif.drdy_in = 1'b0; xif.do_in = 16'h0;
        total++; if (xif.pair_valid !== 1'b1 || xif.switch_sample !== 12'hABC || xif.feed_sample !== 12'h123) begin
            bad++; $display("FAIL basic_pair got=%b/%h/%h exp=1/abc/123", xif.pair_valid, xif.switch_sample, xif.feed_sample); end
        drain();
        total++; if (xif.pair_valid !== 1'b0) begin bad++; $display("FAIL basic_accept got=%b exp=0", xif.pair_valid); end
    endtask

    task automatic test_backpressure();
        int o0;
        o0 = ovr_cnt;
        do_pair(16'h1110, 16'h2220);
        do_pair(16'h3330, 16'h4440);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun got=%b exp=1", overrun); end
        total++; if (xif.pair_valid !== 1'b1 || xif.switch_sample !== 12'h111 || xif.feed_sample !== 12'h222) begin
            bad++; $display("FAIL bp_held got=%b/%h/%h exp=1/111/222", xif.pair_valid, xif.switch_sample, xif.feed_sample); end
        step();
        total++; if (ovr_cnt - o0 != 1) begin bad++; $display("FAIL bp_overrun_cnt got=%0d exp=1", ovr_cnt - o0); end
`ifdef DROP_CNT_EN
        total++; if (drop_count !== 16'd1) begin bad++; $display("FAIL bp_drop got=%0d exp=1", drop_count); end
`endif
        drain();
        total++; if (xif.pair_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", xif.pair_valid); end
    endtask

    task automatic test_simultaneous();
        int o0;
        do_pair(16'h5550, 16'h6660);
        o0 = ovr_cnt;
        eoc_pulse(); step(2); drdy_pulse(16'h7770);
        eoc_pulse(); step(2);
        xif.pair_ready = 1'b1;
        drdy_pulse(16'h8880);
        xif.pair_ready = 1'b0;
        total++; if (xif.pair_valid !== 1'b1 || xif.switch_sample !== 12'h777 || xif.feed_sample !== 12'h888 || overrun !== 1'b0) begin
            bad++; $display("FAIL simul_load got=%b/%h/%h ovr=%b exp=1/777/888 ovr=0",
                            xif.pair_valid, xif.switch_sample, xif.feed_sample, overrun); end
        step(2);
        total++; if (ovr_cnt != o0 || xif.pair_valid !== 1'b1) begin
            bad++; $display("FAIL simul_no_overrun got=%0d pv=%b exp=0 pv=1", ovr_cnt - o0, xif.pair_valid); end
        drain();
    endtask

    task automatic test_timeout();
        // switch read abandoned
        eoc_pulse();
        step(7);
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_early got=%b exp=0", timeout_err); end
        step();
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b exp=1", timeout_err); end
        step();
        total++; if (timeout_err !== 1'b0 || xif.pair_valid !== 1'b0) begin
            bad++; $display("FAIL to_after got=%b pv=%b exp=0 pv=0", timeout_err, xif.pair_valid); end
        eoc_pulse();
        total++; if (xif.den_out !== 1'b1 || xif.daddr_out !== 7'h10) begin
            bad++; $display("FAIL to_restart got=%b/%h exp=1/10", xif.den_out, xif.daddr_out); end
        // drdy in the last allowed cycle wins over the timeout
        step(7); drdy_pulse(16'hAAA0);
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_boundary got=%b exp=0", timeout_err); end
        // feed read abandoned; partial switch sample must not leak into the next pair
        eoc_pulse(); step(8);
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_feed got=%b exp=1", timeout_err); end
        do_pair(16'h1010, 16'h2020);
        total++; if (xif.pair_valid !== 1'b1 || xif.switch_sample !== 12'h101 || xif.feed_sample !== 12'h202) begin
            bad++; $display("FAIL to_nomix got=%b/%h/%h exp=1/101/202", xif.pair_valid, xif.switch_sample, xif.feed_sample); end
`ifdef DROP_CNT_EN
        total++; if (drop_count !== 16'd3) begin bad++; $display("FAIL to_drop got=%0d exp=3", drop_count); end
`endif
        drain();
    endtask

    task automatic test_spurious();
        int d0;
        d0 = den_cnt;
        eoc_pulse();
        step();
        eoc_pulse();
        drdy_pulse(16'h5A50);
        drdy_pulse(16'hFFF0);
        step();
        eoc_pulse(); step(); drdy_pulse(16'h0A50);
        total++; if (den_cnt - d0 != 2) begin bad++; $display("FAIL spur_den got=%0d exp=2", den_cnt - d0); end
        total++; if (xif.pair_valid !== 1'b1 || xif.switch_sample !== 12'h5A5 || xif.feed_sample !== 12'h0A5) begin
            bad++; $display("FAIL spur_pair got=%b/%h/%h exp=1/5a5/0a5", xif.pair_valid, xif.switch_sample, xif.feed_sample); end
        drain();
    endtask

    task automatic test_reset_mid();
        do_pair(16'h9990, 16'h8880);
        eoc_pulse(); step(); drdy_pulse(16'h1230);
        eoc_pulse(); step();
        clr = 1'b1; step(); clr = 1'b0;
        drdy_pulse(16'h7770);
        step(2);
        total++; if (xif.pair_valid !== 1'b0 || xif.switch_sample !== 12'h0 || xif.feed_sample !== 12'h0) begin
            bad++; $display("FAIL rm_pair got=%b/%h/%h exp=0/0/0", xif.pair_valid, xif.switch_sample, xif.feed_sample); end
        total++; if (xif.daddr_out !== 7'h10 || xif.den_out !== 1'b0 || overrun !== 1'b0 || timeout_err !== 1'b0) begin
            bad++; $display("FAIL rm_ctrl got=%h/%b/%b/%b exp=10/0/0/0", xif.daddr_out, xif.den_out, overrun, timeout_err); end
`ifdef DROP_CNT_EN
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL rm_drop got=%0d exp=0", drop_count); end
`endif
        do_pair(16'h4320, 16'h8760);
        total++; if (xif.pair_valid !== 1'b1 || xif.switch_sample !== 12'h432 || xif.feed_sample !== 12'h876) begin
            bad++; $display("FAIL rm_recover got=%b/%h/%h exp=1/432/876", xif.pair_valid, xif.switch_sample, xif.feed_sample); end
    endtask

    initial begin
        xif.eoc_in = 1'b0; xif.drdy_in = 1'b0; xif.do_in = 16'h0; xif.pair_ready = 1'b0;
        step(2);
        test_reset();
        clr = 1'b0;
        step();
        test_basic();
        test_backpressure();
        test_simultaneous();
        test_timeout();
        test_spurious();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
